// File: rtl/clk_div_pkg.sv
// Shared types for the clock divider bank: per-channel config record, lock FSM
// state encoding and the effective-divide helper.
package clk_div_pkg;

   localparam int CFG_W = 16;

   typedef struct packed {
      logic [CFG_W-1:0] div;
      logic [CFG_W-1:0] high;
      logic [CFG_W-1:0] phase;
   } cfg_t;

   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   // A programmed divide of zero behaves as divide-by-one.
   function automatic logic [CFG_W-1:0] eff_div(input logic [CFG_W-1:0] d);
      return (d == '0) ? CFG_W'(1) : d;
   endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration request channel of the clock divider bank (valid/ready).
interface clk_div_bank_if #(
   parameter int CNT_W = 16
) ();

   logic             cfg_valid;
   logic             cfg_ready;
   logic [3:0]       cfg_chan;
   logic [CNT_W-1:0] cfg_div;
   logic [CNT_W-1:0] cfg_high;
   logic [CNT_W-1:0] cfg_phase;

   modport master (
      output cfg_valid, cfg_chan, cfg_div, cfg_high, cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_chan, cfg_div, cfg_high, cfg_phase,
      output cfg_ready
   );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: free-running counter, shadow config applied at the
// period boundary (or on resync) and registered clock / strobe outputs.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int DEF_DIV   = 2,
   parameter int DEF_HIGH  = 1,
   parameter int DEF_PHASE = 0
) (
   input  logic refclk,
   input  logic rst,
   input  logic wr_en,
   input  cfg_t wr_cfg,
   input  logic resync,
   output logic outclk,
   output logic outclk_stb,
   output logic pending,
   output logic applied
);

   localparam cfg_t DEF_CFG = '{div:   CFG_W'(DEF_DIV),
                                high:  CFG_W'(DEF_HIGH),
                                phase: CFG_W'(DEF_PHASE)};

   cfg_t             act;
   cfg_t             shd;
   cfg_t             nxt;
   logic [CFG_W-1:0] cnt;
   logic [CFG_W-1:0] de;
   logic [CFG_W-1:0] nde;
   logic             wrap;

   always_comb begin
      de   = eff_div(act.div);
      wrap = (cnt == de - CFG_W'(1));
      nxt  = pending ? shd : act;
      nde  = eff_div(nxt.div);
   end

   // Applying only at the last count of the old period keeps every period whole.
   assign applied = pending & wrap;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         act        <= DEF_CFG;
         shd        <= DEF_CFG;
         cnt        <= CFG_W'(DEF_PHASE);
         pending    <= 1'b0;
         outclk     <= 1'b0;
         outclk_stb <= 1'b0;
      end else begin
         outclk     <= (cnt < act.high);
         outclk_stb <= (cnt == '0);
         if (resync) begin
            act     <= nxt;
            cnt     <= (nxt.phase < nde) ? nxt.phase : '0;
            pending <= 1'b0;
         end else if (applied) begin
            act     <= shd;
            cnt     <= '0;
            pending <= 1'b0;
         end else begin
            cnt <= wrap ? '0 : cnt + CFG_W'(1);
         end
         // A request in the resync cycle lands after it and stays pending.
         if (wr_en) begin
            shd     <= wr_cfg;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of runtime-reconfigurable clock dividers with a shared lock tracker.
//   state     | meaning
//   ST_SETTLE | settle timer counting down after reset, config apply or resync
//   ST_LOCKED | every channel has run unchanged for LOCK_CYCLES cycles
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int NUM_CLOCKS  = 5,
   parameter int CNT_W       = CFG_W,
   parameter int LOCK_CYCLES = 1024,
   parameter int DEF_DIV     = 2,
   parameter int DEF_HIGH    = 1,
   parameter int DEF_PHASE   = 0
) (
   input  logic                  refclk,
   input  logic                  rst,
   clk_div_bank_if.slave         cfg,
   input  logic                  resync,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] outclk_stb,
   output logic                  locked,
   output logic [NUM_CLOCKS-1:0] cfg_pending
);

   localparam int SW = $clog2(LOCK_CYCLES + 1);

   logic [CNT_W-1:0]      wr_div;
   logic [CNT_W-1:0]      wr_high;
   logic [CNT_W-1:0]      wr_phase;
   cfg_t                  wr_cfg;
   logic [15:0]           pend_pad;
   logic                  accept;
   logic [NUM_CLOCKS-1:0] applied;
   logic                  evt;
   lock_state_t           state;
   lock_state_t           state_nxt;
   logic [SW-1:0]         settle;
   logic [SW-1:0]         settle_nxt;

   assign wr_div   = cfg.cfg_div;
   assign wr_high  = cfg.cfg_high;
   assign wr_phase = cfg.cfg_phase;
   assign wr_cfg   = '{div: CFG_W'(wr_div), high: CFG_W'(wr_high), phase: CFG_W'(wr_phase)};

   // Unused channel slots read as never pending, so out-of-range requests are taken and dropped.
   assign pend_pad      = 16'(cfg_pending);
   assign cfg.cfg_ready = ~pend_pad[cfg.cfg_chan];
   assign accept        = cfg.cfg_valid & cfg.cfg_ready;

   for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
      clk_div_chan #(
         .DEF_DIV   (DEF_DIV),
         .DEF_HIGH  (DEF_HIGH),
         .DEF_PHASE (DEF_PHASE)
      ) u_chan (
         .refclk     (refclk),
         .rst        (rst),
         .wr_en      (accept && (cfg.cfg_chan == 4'(i))),
         .wr_cfg     (wr_cfg),
         .resync     (resync),
         .outclk     (outclk[i]),
         .outclk_stb (outclk_stb[i]),
         .pending    (cfg_pending[i]),
         .applied    (applied[i])
      );
   end

   assign evt = resync | (|applied);

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state  <= ST_SETTLE;
         settle <= SW'(LOCK_CYCLES - 1);
         locked <= 1'b0;
      end else begin
         state  <= state_nxt;
         settle <= settle_nxt;
         locked <= (state == ST_LOCKED);
      end
   end

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle;
      if (evt) begin
         state_nxt  = ST_SETTLE;
         settle_nxt = SW'(LOCK_CYCLES - 1);
      end else begin
         case (state)
            ST_SETTLE: begin
               if (settle == '0) state_nxt = ST_LOCKED;
               else              settle_nxt = settle - SW'(1);
            end
            ST_LOCKED: ;
            default:   state_nxt = ST_SETTLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scenario bench for clk_div_bank: a cycle model feeds an expected-output queue
// that is compared every cycle, alongside directed checks per scenario.
module tb_clk_div_bank;

   localparam int N = 5;
   localparam int W = 16;
   localparam int L = 16;

   logic         refclk = 1'b0;
   logic         rst    = 1'b0;
   logic         resync = 1'b0;
   logic [N-1:0] outclk;
   logic [N-1:0] outclk_stb;
   logic [N-1:0] cfg_pending;
   logic         locked;
   int           checks = 0;
   int           errors = 0;

   clk_div_bank_if #(.CNT_W(W)) cfg ();

   clk_div_bank #(
      .NUM_CLOCKS  (N),
      .CNT_W       (W),
      .LOCK_CYCLES (L),
      .DEF_DIV     (2),
      .DEF_HIGH    (1),
      .DEF_PHASE   (0)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .cfg         (cfg),
      .resync      (resync),
      .outclk      (outclk),
      .outclk_stb  (outclk_stb),
      .locked      (locked),
      .cfg_pending (cfg_pending)
   );

   always #5 refclk = ~refclk;

   typedef struct packed {
      logic [N-1:0] clk;
      logic [N-1:0] stb;
      logic [N-1:0] pend;
      logic         lk;
   } exp_t;

   exp_t exp_q[$];

   int m_cnt[N], m_div[N], m_high[N], m_phase[N];
   int s_div[N], s_high[N], s_phase[N];
   bit m_pend[N];
   int since;

   function automatic int de_of(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   // Reference model: pushes the outputs expected after each active edge.
   initial forever begin
      exp_t e;
      bit   evt;
      bit   acc;
      int   ch;
      @(posedge refclk or posedge rst);
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_div[i] = 2; m_high[i] = 1; m_phase[i] = 0; m_pend[i] = 0;
            s_div[i] = 2; s_high[i] = 1; s_phase[i] = 0;
         end
         since = 0;
         exp_q.delete();
      end else begin
         ch   = int'(cfg.cfg_chan);
         acc  = cfg.cfg_valid && ((ch >= N) || !m_pend[ch]);
         evt  = resync;
         e    = '0;
         e.lk = (since >= L);
         for (int i = 0; i < N; i++) begin
            e.clk[i] = (m_cnt[i] < m_high[i]);
            e.stb[i] = (m_cnt[i] == 0);
            if (resync) begin
               if (m_pend[i]) begin
                  m_div[i] = s_div[i]; m_high[i] = s_high[i]; m_phase[i] = s_phase[i];
               end
               m_cnt[i]  = (m_phase[i] < de_of(m_div[i])) ? m_phase[i] : 0;
               m_pend[i] = 0;
            end else if (m_pend[i] && (m_cnt[i] == de_of(m_div[i]) - 1)) begin
               m_div[i] = s_div[i]; m_high[i] = s_high[i]; m_phase[i] = s_phase[i];
               m_cnt[i]  = 0;
               m_pend[i] = 0;
               evt       = 1;
            end else begin
               m_cnt[i] = (m_cnt[i] + 1) % de_of(m_div[i]);
            end
            if (acc && (ch == i)) begin
               s_div[i]   = int'(cfg.cfg_div);
               s_high[i]  = int'(cfg.cfg_high);
               s_phase[i] = int'(cfg.cfg_phase);
               m_pend[i]  = 1;
            end
            e.pend[i] = m_pend[i];
         end
         since = evt ? 0 : since + 1;
         exp_q.push_back(e);
      end
   end

   initial forever begin
      exp_t e;
      @(posedge refclk);
      #1;
      if (!rst && (exp_q.size() > 0)) begin
         e = exp_q.pop_front();
         checks++;
         if ({outclk, outclk_stb, cfg_pending, locked} !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got clk=%b stb=%b pend=%b lk=%b expected clk=%b stb=%b pend=%b lk=%b",
                     $time, outclk, outclk_stb, cfg_pending, locked, e.clk, e.stb, e.pend, e.lk);
         end
      end
   end

   task automatic cfg_write(input int ch, input int d, input int h, input int p);
      @(negedge refclk);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_chan  = 4'(ch);
      cfg.cfg_div   = W'(d);
      cfg.cfg_high  = W'(h);
      cfg.cfg_phase = W'(p);
      @(negedge refclk);
      cfg.cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      cfg.cfg_valid = 1'b0; cfg.cfg_chan = '0;
      cfg.cfg_div = '0; cfg.cfg_high = '0; cfg.cfg_phase = '0;
      resync = 1'b0;
      rst    = 1'b1;
      repeat (2) @(negedge refclk);
      checks++;
      if (outclk !== '0 || outclk_stb !== '0) begin
         errors++; $display("FAIL reset_outputs got clk=%b stb=%b expected 0", outclk, outclk_stb);
      end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b expected 0", locked); end
      checks++;
      if (cfg_pending !== '0) begin errors++; $display("FAIL reset_pending got %b expected 0", cfg_pending); end
      checks++;
      if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", cfg.cfg_ready); end
   endtask

   task automatic test_lock();
      int k = 0;
      rst = 1'b0;
      for (int c = 1; c <= L + 20; c++) begin
         @(posedge refclk); #1;
         if (c == 1) begin
            checks++;
            if (outclk !== '1 || outclk_stb !== '1) begin
               errors++; $display("FAIL default_first got clk=%b stb=%b expected all ones", outclk, outclk_stb);
            end
         end
         if (c == 2) begin
            checks++;
            if (outclk !== '0 || outclk_stb !== '0) begin
               errors++; $display("FAIL default_second got clk=%b stb=%b expected zeros", outclk, outclk_stb);
            end
         end
         if (locked === 1'b1) begin k = c; break; end
      end
      checks++;
      if (k != L + 1) begin errors++; $display("FAIL lock_time got edge %0d expected %0d", k, L + 1); end
   endtask

   task automatic test_reconfig();
      int a = 0;
      cfg_write(0, 5, 2, 0);
      checks++;
      if (cfg_pending[0] !== 1'b1) begin errors++; $display("FAIL pend0_set got %b expected 1", cfg_pending[0]); end
      for (int c = 1; c <= 10; c++) begin
         @(posedge refclk); #1;
         if (cfg_pending[0] === 1'b0) begin a = c; break; end
      end
      checks++;
      if (a == 0) begin errors++; $display("FAIL apply_timeout got pending=%b expected 0", cfg_pending[0]); end
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL lock_hold_on_apply got %b expected 1", locked); end
      for (int j = 0; j < 10; j++) begin
         @(posedge refclk); #1;
         if (j == 0) begin
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL lock_drop got %b expected 0", locked); end
         end
         checks++;
         if (outclk[0] !== ((j % 5) < 2)) begin
            errors++; $display("FAIL div5_pattern j=%0d got %b expected %b", j, outclk[0], ((j % 5) < 2));
         end
      end
      a = 0;
      for (int c = 11; c <= L + 30; c++) begin
         @(posedge refclk); #1;
         if (locked === 1'b1) begin a = c; break; end
      end
      checks++;
      if (a != L + 1) begin errors++; $display("FAIL relock got edge %0d expected %0d", a, L + 1); end
   endtask

   task automatic test_ready();
      @(negedge refclk);
      cfg.cfg_valid = 1'b1; cfg.cfg_chan = 4'd0;
      cfg.cfg_div = W'(0); cfg.cfg_high = W'(1); cfg.cfg_phase = W'(0);
      @(negedge refclk); #1;
      checks++;
      if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_busy got %b expected 0", cfg.cfg_ready); end
      cfg.cfg_chan = 4'd1;
      cfg.cfg_div = W'(4); cfg.cfg_high = W'(2); cfg.cfg_phase = W'(2);
      #1;
      checks++;
      if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_other got %b expected 1", cfg.cfg_ready); end
      @(negedge refclk);
      cfg.cfg_valid = 1'b0;
      checks++;
      if (cfg_pending[1] !== 1'b1) begin errors++; $display("FAIL pend1_set got %b expected 1", cfg_pending[1]); end
   endtask

   task automatic test_resync();
      cfg_write(2, 4, 2, 0);
      cfg_write(3, 4, 2, 7);
      @(negedge refclk);
      resync = 1'b1;
      cfg.cfg_valid = 1'b1; cfg.cfg_chan = 4'd4;
      cfg.cfg_div = W'(3); cfg.cfg_high = W'(0); cfg.cfg_phase = W'(0);
      @(negedge refclk);
      resync = 1'b0;
      cfg.cfg_valid = 1'b0;
      checks++;
      if (cfg_pending !== 5'b10000) begin
         errors++; $display("FAIL resync_pending got %b expected 10000", cfg_pending);
      end
      for (int j = 0; j < 8; j++) begin
         @(posedge refclk); #1;
         checks++;
         if (outclk[1] !== ((j % 4) >= 2) || outclk[2] !== ((j % 4) < 2) || outclk[3] !== ((j % 4) < 2) ||
             outclk_stb[1] !== ((j % 4) == 2) || outclk_stb[2] !== ((j % 4) == 0)) begin
            errors++;
            $display("FAIL resync_phase j=%0d got clk=%b stb=%b", j, outclk, outclk_stb);
         end
      end
   endtask

   task automatic test_edges();
      int a = 0;
      cfg_write(3, 4, 9, 0);
      for (int c = 1; c <= 50; c++) begin
         @(posedge refclk); #1;
         if (cfg_pending === '0) begin a = c; break; end
      end
      checks++;
      if (a == 0) begin errors++; $display("FAIL edge_apply_timeout got pending=%b expected 0", cfg_pending); end
      for (int j = 0; j < 8; j++) begin
         @(posedge refclk); #1;
         checks++;
         if (outclk[4] !== 1'b0 || outclk[3] !== 1'b1 || outclk[0] !== 1'b1 || outclk_stb[0] !== 1'b1) begin
            errors++;
            $display("FAIL edge_values j=%0d got clk=%b stb=%b expected clk[4]=0 clk[3]=1 clk[0]=1 stb[0]=1",
                     j, outclk, outclk_stb);
         end
      end
      @(negedge refclk);
      cfg.cfg_valid = 1'b1; cfg.cfg_chan = 4'd12;
      cfg.cfg_div = W'(3); cfg.cfg_high = W'(1); cfg.cfg_phase = W'(0);
      #1;
      checks++;
      if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL chan12_ready got %b expected 1", cfg.cfg_ready); end
      @(negedge refclk);
      cfg.cfg_valid = 1'b0;
      checks++;
      if (cfg_pending !== '0) begin errors++; $display("FAIL chan12_dropped got pending=%b expected 0", cfg_pending); end
   endtask

   task automatic test_reset_mid();
      int           a = 0;
      logic [N-1:0] expv;
      for (int c = 1; c <= L + 40; c++) begin
         @(posedge refclk); #1;
         if (locked === 1'b1) begin a = c; break; end
      end
      checks++;
      if (a == 0) begin errors++; $display("FAIL premid_lock got %b expected 1", locked); end
      cfg_write(1, 6, 3, 0);
      checks++;
      if (cfg_pending[1] !== 1'b1) begin errors++; $display("FAIL mid_pend_set got %b expected 1", cfg_pending[1]); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (outclk !== '0 || outclk_stb !== '0) begin
         errors++; $display("FAIL mid_reset_outputs got clk=%b stb=%b expected 0", outclk, outclk_stb);
      end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL mid_reset_locked got %b expected 0", locked); end
      checks++;
      if (cfg_pending !== '0) begin errors++; $display("FAIL mid_reset_pending got %b expected 0", cfg_pending); end
      @(negedge refclk);
      rst = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge refclk); #1;
         expv = (c % 2 == 1) ? {N{1'b1}} : '0;
         checks++;
         if (outclk !== expv || outclk_stb !== expv || cfg_pending !== '0) begin
            errors++;
            $display("FAIL post_reset_defaults c=%0d got clk=%b stb=%b pend=%b expected clk=stb=%b pend=0",
                     c, outclk, outclk_stb, cfg_pending, expv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_reconfig();
      test_ready();
      test_resync();
      test_edges();
      test_reset_mid();
      repeat (4) @(negedge refclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
